hex_display_scan: RTL and testbench

HEX_DISPLAY_SCAN -- requirements
Module: hex_display_scan

---
 rtl/hex_display_scan.sv | 140 ++++++++++++++
 tb/tb_hex_display_scan.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_scan.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous value commit
// and optional leading-zero blanking.
module hex_display_scan #(
    parameter int unsigned SCAN_DIV = 100_000
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        load,
    input  logic [15:0] din,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        pending,
    output logic        frame_done
);

    localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

    logic [CntW-1:0] presc_q, presc_d;
    logic [1:0]      idx_q, idx_d;
    logic            tick;
    logic            frame_end;

    // {dp[3:0], digits[15:0]}
    logic [19:0]     pend_val_q, pend_val_d;
    logic [19:0]     disp_q, disp_d;
    logic            pending_q, pending_d;

    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic [3:0]      cur_digit;
    logic [3:0]      digit_zero;
    logic [3:0]      lead_zero;
    logic            blanked;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

    assign tick      = (presc_q == CntMax);
    assign frame_end = tick && (idx_q == 2'd3);

    always_comb begin
        presc_d = tick ? '0 : presc_q + CntW'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;
    end

    // Commit of the old pending value takes priority; a simultaneous load re-arms pending.
    always_comb begin
        pend_val_d = pend_val_q;
        disp_d     = disp_q;
        pending_d  = pending_q;
        if (frame_end && pending_q) begin
            disp_d    = pend_val_q;
            pending_d = 1'b0;
        end
        if (load) begin
            pend_val_d = {dp_in, din};
            pending_d  = 1'b1;
        end
    end

    always_comb begin
        digit_zero = {disp_q[15:12] == 4'h0, disp_q[11:8] == 4'h0,
                      disp_q[7:4] == 4'h0, disp_q[3:0] == 4'h0};
        lead_zero  = {digit_zero[3],
                      digit_zero[3] & digit_zero[2],
                      digit_zero[3] & digit_zero[2] & digit_zero[1],
                      1'b0};
        case (idx_q)
            2'd0:    cur_digit = disp_q[3:0];
            2'd1:    cur_digit = disp_q[7:4];
            2'd2:    cur_digit = disp_q[11:8];
            default: cur_digit = disp_q[15:12];
        endcase
        blanked = blank_lz & lead_zero[idx_q];

        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (!blanked) begin
            an_d[idx_q] = 1'b0;
            seg_d       = hex_to_seg(cur_digit);
            dp_d        = ~disp_q[16 + {30'd0, idx_q}];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc_q    <= '0;
            idx_q      <= 2'd0;
            pend_val_q <= '0;
            disp_q     <= '0;
            pending_q  <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            disp_q     <= disp_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign pending    = pending_q;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_hex_display_scan.sv
// Bench for hex_display_scan at SCAN_DIV=4: reference model checked every clock,
// plus table-driven frame contents and hand-written commit/reset corner cases.
module tb_hex_display_scan;

    logic        clk;
    logic        clr;
    logic        load_r;
    logic [15:0] din_r;
    logic [3:0]  dpin_r;
    logic        blz_r;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        pending;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;

    // Reference model state: edges since reset release, display / pending contents.
    int          m;
    logic [19:0] m_disp;
    logic [19:0] m_pval;
    logic        m_pend;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    typedef struct packed {
        logic [15:0] din;
        logic [3:0]  dpi;
        logic        blz;
        logic [27:0] seg4;
        logic [15:0] an4;
        logic [3:0]  dp4;
    } vec_t;

    vec_t vecs [5];

    hex_display_scan #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .load       (load_r),
        .din        (din_r),
        .dp_in      (dpin_r),
        .blank_lz   (blz_r),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {an, seg, dp} for a given display value, slot and blanking mode.
    function automatic logic [11:0] model_out(input logic [19:0] v, input int idx,
                                              input logic blz);
        int unsigned d;
        int unsigned upper;
        logic [3:0]  a;
        d     = 32'(v[15:0]);
        upper = d >> (4 * idx);
        if (blz && idx != 0 && upper == 0) return {4'hF, 7'h7F, 1'b1};
        a = 4'hF & ~(4'b0001 << idx);
        return {a, seg_tab[upper & 15], ~v[16 + idx]};
    endfunction

    task automatic model_reset();
        m      = 0;
        m_disp = '0;
        m_pval = '0;
        m_pend = 1'b0;
    endtask

    task automatic step();
        logic [11:0] e;
        @(posedge clk);
        m++;
        e = model_out(m_disp, ((m - 1) / 4) % 4, blz_r);
        if (m % 16 == 0 && m_pend) begin
            m_disp = m_pval;
            m_pend = 1'b0;
        end
        if (load_r) begin
            m_pval = {dpin_r, din_r};
            m_pend = 1'b1;
        end
        #1;
        load_r = 1'b0;
        chk("an", 32'(an), 32'(e[11:8]));
        chk("seg", 32'(seg), 32'(e[7:1]));
        chk("dp", 32'(dp), 32'(e[0]));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("frame_done", 32'(frame_done), 32'(m % 16 == 15));
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_done !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("frame_wait", 32'(frame_done), 32'd1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        din_r  = d;
        dpin_r = p;
        load_r = 1'b1;
        step();
    endtask

    task automatic async_reset();
        #3;
        clr = 1'b1;
        #1;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_reset();
    endtask

    initial begin
        vecs[0] = '{din: 16'h1A8F, dpi: 4'b0100, blz: 1'b0,
                    seg4: {7'b1001111, 7'b0001000, 7'b0000000, 7'b0111000},
                    an4: 16'b0111_1011_1101_1110, dp4: 4'b1011};
        vecs[1] = '{din: 16'h0050, dpi: 4'b0000, blz: 1'b1,
                    seg4: {7'h7F, 7'h7F, 7'b0100100, 7'b0000001},
                    an4: 16'b1111_1111_1101_1110, dp4: 4'b1111};
        vecs[2] = '{din: 16'h0000, dpi: 4'b1111, blz: 1'b1,
                    seg4: {7'h7F, 7'h7F, 7'h7F, 7'b0000001},
                    an4: 16'b1111_1111_1111_1110, dp4: 4'b1110};
        vecs[3] = '{din: 16'hB0C0, dpi: 4'b1000, blz: 1'b1,
                    seg4: {7'b1100000, 7'b0000001, 7'b0110001, 7'b0000001},
                    an4: 16'b0111_1011_1101_1110, dp4: 4'b0111};
        vecs[4] = '{din: 16'h0D00, dpi: 4'b0010, blz: 1'b1,
                    seg4: {7'h7F, 7'b1000010, 7'b0000001, 7'b0000001},
                    an4: 16'b1111_1011_1101_1110, dp4: 4'b1101};

        clr    = 1'b1;
        load_r = 1'b0;
        din_r  = '0;
        dpin_r = '0;
        blz_r  = 1'b0;
        model_reset();
        #3;
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'd1);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;

        // Free-running scan of a zero display.
        step();
        chk("first_an", 32'(an), 32'b1110);
        chk("first_seg", 32'(seg), 32'b0000001);
        steps(40);

        // Table of display values: each one shown for a full frame.
        foreach (vecs[k]) begin
            blz_r = vecs[k].blz;
            do_load(vecs[k].din, vecs[k].dpi);
            wait_frame();
            steps(2);
            for (int d = 0; d < 4; d++) begin
                if (d != 0) steps(4);
                chk($sformatf("vec%0d_an%0d", k, d), 32'(an), 32'(vecs[k].an4[4*d +: 4]));
                chk($sformatf("vec%0d_seg%0d", k, d), 32'(seg), 32'(vecs[k].seg4[7*d +: 7]));
                chk($sformatf("vec%0d_dp%0d", k, d), 32'(dp), 32'(vecs[k].dp4[d]));
            end
        end
        blz_r = 1'b0;

        // Last write wins within one frame.
        wait_frame();
        step();
        do_load(16'h1111, 4'h0);
        step();
        do_load(16'h2222, 4'h0);
        chk("lww_pending", 32'(pending), 32'd1);
        wait_frame();
        steps(2);
        for (int d = 0; d < 4; d++) begin
            if (d != 0) steps(4);
            chk("lww_seg", 32'(seg), 32'b0010010);
        end

        // Load coincident with a frame boundary while another value is pending.
        do_load(16'h4444, 4'h0);
        wait_frame();
        chk("coin_pend_before", 32'(pending), 32'd1);
        do_load(16'h3333, 4'h0);
        chk("coin_pend_after", 32'(pending), 32'd1);
        step();
        chk("coin_first", 32'(seg), 32'b1001100);
        wait_frame();
        steps(2);
        chk("coin_second", 32'(seg), 32'b0000110);
        chk("coin_pend_clear", 32'(pending), 32'd0);

        // Reset during a digit-2 slot with a value pending.
        wait_frame();
        step();
        do_load(16'h9876, 4'hF);
        for (int n = 0; n < 20 && an !== 4'b1011; n++) step();
        chk("mid_slot2", 32'(an), 32'b1011);
        chk("mid_pending", 32'(pending), 32'd1);
        async_reset();
        step();
        chk("post_rst_an", 32'(an), 32'b1110);
        chk("post_rst_seg", 32'(seg), 32'b0000001);
        chk("post_rst_dp", 32'(dp), 32'd1);
        steps(20);

        // Randomized loads and blanking mode against the model.
        for (int i = 0; i < 600; i++) begin
            if (i % 64 == 0) blz_r = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                din_r  = 16'($urandom);
                if ($urandom_range(0, 2) == 0) din_r = din_r >> (4 * $urandom_range(1, 4));
                dpin_r = 4'($urandom);
                load_r = 1'b1;
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
